// File: rtl/raw_pattern_streamer.sv
// rtl/raw_pattern_streamer.sv - RAW8/10/12 Bayer test-pattern line streamer
module raw_pattern_streamer #(
   parameter int N_MIPI_LANES    = 2,
   parameter int BUS_WIDTH       = 8,
   parameter int BPP             = 10,
   parameter int PIXELS_PER_LINE = 3240,
   parameter int LINES_PER_FRAME = 1080,
   parameter int BAYER_ORDER     = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_start,
   input  logic                      line_start,
   input  logic [1:0]                pattern_mode,
   output logic [N_MIPI_LANES*8-1:0] out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      overrun,
   output logic [15:0]               frame_cnt,
   output logic [15:0]               line_cnt
);

   localparam int BEATS = PIXELS_PER_LINE * BPP / (8 * N_MIPI_LANES);
   localparam int GB    = (BPP == 8) ? 1 : (BPP == 10) ? 5 : 3;
   localparam int GP    = (BPP == 8) ? 1 : (BPP == 10) ? 4 : 2;
   localparam int BW    = $clog2(BEATS + 1);
   // {row, col} of the red site inside the 2x2 Bayer tile; blue sits diagonally opposite.
   localparam logic [1:0] RPOS = (BAYER_ORDER == 0) ? 2'b11 : (BAYER_ORDER == 1) ? 2'b00 :
                                 (BAYER_ORDER == 2) ? 2'b10 : 2'b01;

   generate
      if (BUS_WIDTH != 8 ||
          !(N_MIPI_LANES == 1 || N_MIPI_LANES == 2 || N_MIPI_LANES == 4) ||
          !(BPP == 8 || BPP == 10 || BPP == 12) ||
          ((PIXELS_PER_LINE * BPP) % (8 * N_MIPI_LANES)) != 0) begin : g_bad_cfg
         $error("raw_pattern_streamer: illegal parameter combination");
      end
   endgenerate

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                    state_q, state_d;
   logic [N_MIPI_LANES*8-1:0] out_data_q, beat_d;
   logic                      out_last_q, overrun_q, seen_q;
   logic [BW-1:0]             beat_q;
   logic [15:0]               grp_q, nxt_g, cur_g;
   logic [2:0]                pos_q, nxt_p, cur_p;
   logic [1:0]                mode_q, cur_mode;
   logic [15:0]               frame_cnt_q, line_cnt_q, frame_eff, line_eff;
   logic                      accept;

   function automatic logic [11:0] pix(input logic [15:0] x, input logic [1:0] mode,
                                       input logic [15:0] line, input logic [15:0] frame);
      logic [15:0] sum;
      logic [11:0] mask;
      logic [1:0]  site;
      mask = 12'((1 << BPP) - 1);
      sum  = x + frame;
      site = {line[0], x[0]};
      case (mode)
         2'd0:    return sum[11:0] & mask;
         2'd1:    return (site == RPOS) ? mask : (site == ~RPOS) ? 12'd0 : 12'(1 << (BPP - 1));
         2'd2:    return line[11:0] & mask;
         default: return 12'd0;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [15:0] g, input logic [2:0] p,
                                          input logic [1:0] mode, input logic [15:0] line,
                                          input logic [15:0] frame);
      logic [11:0] p0, p1, p2, p3, pp;
      p0 = pix(g, mode, line, frame);
      p1 = pix(g + 16'd1, mode, line, frame);
      p2 = pix(g + 16'd2, mode, line, frame);
      p3 = pix(g + 16'd3, mode, line, frame);
      pp = pix(g + 16'(p), mode, line, frame);
      if (BPP == 8)       return pp[7:0];
      else if (BPP == 10) return (p == 3'd4) ? {p3[1:0], p2[1:0], p1[1:0], p0[1:0]} : pp[9:2];
      else                return (p == 3'd2) ? {p1[3:0], p0[3:0]} : pp[11:4];
   endfunction

   assign accept = (state_q == IDLE) && line_start;

   // Byte cursor (group base pixel, position in group) walks across lanes so groups can straddle beats.
   always_comb begin
      cur_g    = accept ? 16'd0 : grp_q;
      cur_p    = accept ? 3'd0 : pos_q;
      cur_mode = accept ? pattern_mode : mode_q;
      frame_eff = frame_cnt_q;
      line_eff  = line_cnt_q;
      if (state_q == IDLE && frame_start) begin
         frame_eff = seen_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
         line_eff  = 16'd0;
      end
      beat_d = '0;
      for (int k = 0; k < N_MIPI_LANES; k++) begin
         beat_d[k*8 +: 8] = byte_of(cur_g, cur_p, cur_mode, line_eff, frame_eff);
         if (cur_p == 3'(GB - 1)) begin
            cur_p = 3'd0;
            cur_g = cur_g + 16'(GP);
         end else begin
            cur_p = cur_p + 3'd1;
         end
      end
      nxt_g = cur_g;
      nxt_p = cur_p;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (line_start) state_d = ACTIVE;
         default: if (out_ready && out_last_q) state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == ACTIVE);
      out_valid = (state_q == ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
         seen_q      <= 1'b0;
         beat_q      <= '0;
         grp_q       <= '0;
         pos_q       <= '0;
         mode_q      <= '0;
         frame_cnt_q <= '0;
         line_cnt_q  <= '0;
      end else if (state_q == IDLE) begin
         if (frame_start) begin
            frame_cnt_q <= frame_eff;
            line_cnt_q  <= 16'd0;
            seen_q      <= 1'b1;
         end
         if (line_start) begin
            mode_q     <= pattern_mode;
            out_data_q <= beat_d;
            grp_q      <= nxt_g;
            pos_q      <= nxt_p;
            beat_q     <= BW'(1);
            out_last_q <= (BEATS == 1);
         end
      end else begin
         if (line_start || frame_start) overrun_q <= 1'b1;
         if (out_ready) begin
            if (out_last_q) begin
               out_last_q <= 1'b0;
               line_cnt_q <= (line_cnt_q == 16'(LINES_PER_FRAME - 1)) ? 16'd0 : line_cnt_q + 16'd1;
            end else begin
               out_data_q <= beat_d;
               grp_q      <= nxt_g;
               pos_q      <= nxt_p;
               beat_q     <= beat_q + BW'(1);
               out_last_q <= (beat_q == BW'(BEATS - 1));
            end
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign overrun   = overrun_q;
   assign frame_cnt = frame_cnt_q;
   assign line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_raw_pattern_streamer.sv
// tb/tb_raw_pattern_streamer.sv - randomized self-checking bench for raw_pattern_streamer
module tb_raw_pattern_streamer;
   localparam int N   = 2;
   localparam int BPP = 10;
   localparam int PPL = 8;
   localparam int LPF = 2;
   localparam int BEATS = PPL * BPP / (8 * N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0, line_start = 1'b0, out_ready = 1'b0;
   logic [1:0]    pattern_mode = 2'd0;
   logic [N*8-1:0] out_data;
   logic          out_valid, out_last, busy, overrun;
   logic [15:0]   frame_cnt, line_cnt;

   raw_pattern_streamer #(
      .N_MIPI_LANES(N), .BUS_WIDTH(8), .BPP(BPP), .PIXELS_PER_LINE(PPL),
      .LINES_PER_FRAME(LPF), .BAYER_ORDER(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
      .pattern_mode(pattern_mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun),
      .frame_cnt(frame_cnt), .line_cnt(line_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_frame = 0;
   int m_line = 0;
   bit m_seen = 1'b0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pix(input int x, input int mode);
      case (mode)
         0: return (x + m_frame) % 1024;
         1: begin
            // BGGR: even row B G B G, odd row G R G R
            if ((m_line % 2) == 0 && (x % 2) == 0) return 0;
            if ((m_line % 2) == 1 && (x % 2) == 1) return 1023;
            return 512;
         end
         2: return m_line % 1024;
         default: return 0;
      endcase
   endfunction

   task automatic build_line(input int mode);
      int p[PPL];
      exp_q.delete();
      for (int x = 0; x < PPL; x++) p[x] = model_pix(x, mode);
      for (int g = 0; g < PPL; g += 4) begin
         for (int k = 0; k < 4; k++) exp_q.push_back(8'(p[g+k] / 4));
         exp_q.push_back(8'(((p[g+3] % 4) * 64) + ((p[g+2] % 4) * 16) + ((p[g+1] % 4) * 4) + (p[g] % 4)));
      end
   endtask

   task automatic model_frame_start();
      if (m_seen) m_frame = (m_frame + 1) % 65536;
      m_seen = 1'b1;
      m_line = 0;
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 three-cycle stall after two cycles
   task automatic run_line(input bit fs, input int mode, input int rdy_mode, input bit inject,
                           input int abort_at);
      int cyc, beats;
      bit stalled, done, r;
      logic [N*8-1:0] held, exp_beat;
      logic held_last;
      if (fs) model_frame_start();
      build_line(mode);
      frame_start  = fs;
      line_start   = 1'b1;
      pattern_mode = 2'(mode);
      out_ready    = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      line_start  = 1'b0;
      chk("accept_frame_cnt", frame_cnt, 32'(m_frame));
      chk("accept_line_cnt", line_cnt, 32'(m_line));
      cyc = 0; beats = 0; stalled = 1'b0; done = 1'b0; held = '0; held_last = 1'b0;
      while (!done && cyc < 200) begin
         if (stalled) begin
            chk("hold_data", out_data, held);
            chk("hold_last", out_last, held_last);
         end
         chk("valid_high", out_valid, 1);
         if (!out_valid) begin
            done = 1'b1;
         end else begin
            case (rdy_mode)
               0:       r = 1'b1;
               1:       r = ($urandom_range(0, 3) != 0);
               default: r = !(cyc >= 2 && cyc < 5);
            endcase
            out_ready  = r;
            line_start = inject && (cyc == 1);
            if (r) begin
               beats++;
               if (exp_q.size() < N) begin
                  chk("beat_count", beats, BEATS);
                  done = 1'b1;
               end else begin
                  exp_beat = {exp_q[1], exp_q[0]};
                  void'(exp_q.pop_front());
                  void'(exp_q.pop_front());
                  chk("beat_data", out_data, exp_beat);
                  chk("beat_last", out_last, 32'(exp_q.size() == 0));
                  if (out_last) done = 1'b1;
               end
            end
            stalled   = !r;
            held      = out_data;
            held_last = out_last;
            if (abort_at != 0 && beats == abort_at) done = 1'b1;
         end
         if (!(abort_at != 0 && beats == abort_at)) begin
            @(negedge clk);
            cyc++;
         end
      end
      line_start = 1'b0;
      out_ready  = 1'b1;
      chk("line_done", done, 1);
      if (abort_at == 0) begin
         m_line = (m_line + 1) % LPF;
         chk("end_busy", busy, 0);
         chk("end_valid", out_valid, 0);
         chk("end_line_cnt", line_cnt, 32'(m_line));
         chk("end_frame_cnt", frame_cnt, 32'(m_frame));
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_line_cnt", line_cnt, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_state();
      rst_n = 1'b1;
      @(negedge clk);

      run_line(1'b1, 0, 0, 1'b0, 0);
      run_line(1'b0, 1, 0, 1'b0, 0);

      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      model_frame_start();
      chk("fs_frame_cnt", frame_cnt, 32'(m_frame));
      chk("fs_line_cnt", line_cnt, 0);

      run_line(1'b0, 1, 1, 1'b0, 0);
      run_line(1'b0, 2, 2, 1'b0, 0);
      for (int i = 0; i < 8; i++)
         run_line(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 1'b0, 0);

      chk("pre_overrun", overrun, 0);
      run_line(1'b0, 0, 0, 1'b1, 0);
      chk("overrun_set", overrun, 1);
      run_line(1'b0, 1, 1, 1'b0, 0);
      run_line(1'b0, 0, 0, 1'b0, 0);
      chk("overrun_sticky", overrun, 1);

      run_line(1'b0, 0, 0, 1'b0, 3);
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      m_frame = 0; m_line = 0; m_seen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run_line(1'b0, 0, 1, 1'b0, 0);
      run_line(1'b1, 0, 0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end
endmodule
